// File: rtl/seq_divider_8bit_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_div_pkg;

    localparam int SEQ_DIV_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_div_state_t;

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Request/result bundle between the requester (master) and the divider (slave).
interface seq_divider_8bit_if
    import seq_div_pkg::*;
#(
    parameter int N = SEQ_DIV_N_DEFAULT
) ();

    // Handshake: start is taken only when the divider is in IDLE or DONE (busy low);
    // while busy it is ignored. done pulses for exactly one cycle when the results
    // and flags become valid; they then hold until the next accepted start.
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             overflow;
    seq_div_state_t   state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow, state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow, state
    );

endinterface

// File: rtl/seq_divider_8bit_step.sv
// One combinational restoring-division step: shift {R,Q} left, subtract if it fits.
module seq_div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [2*N:0] shifted;
    logic [N:0]   r_sh;
    logic [N-1:0] q_sh;

    assign shifted = {r, q} << 1;
    assign r_sh    = shifted[2*N:N];
    assign q_sh    = shifted[N-1:0];

    always_comb begin
        r_next = r_sh;
        q_next = q_sh;
        if (r_sh >= {1'b0, divisor}) begin
            r_next = r_sh - {1'b0, divisor};
            q_next = {q_sh[N-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional simulation checks are compiled when SEQ_DIV_CHECK_EN is defined.
module seq_divider_8bit
    import seq_div_pkg::*;
#(
    parameter int N = SEQ_DIV_N_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    seq_divider_8bit_if.slave bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    seq_div_state_t state, state_nxt;
    logic [N:0]     r_q, r_step;
    logic [N-1:0]   q_q, q_step, dvs_q, quo_q, rem_q;
    logic           dbz_q, ovf_q;
    logic [CW-1:0]  cnt_q;
    logic           accept, last, is_zero, is_ovf;

    assign accept  = (state != RUN) && bus.start;
    assign is_zero = (bus.divisor == '0);
    assign is_ovf  = (bus.dividend[2*N-1:N] >= bus.divisor);
    assign last    = (cnt_q == CW'(N - 1));

    seq_div_step #(.N(N)) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (dvs_q),
        .r_next  (r_step),
        .q_next  (q_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) state_nxt = (is_zero || is_ovf) ? DONE : RUN;
                else           state_nxt = IDLE;
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Error cases resolve on the accept edge; normal results load only on the last RUN step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            dvs_q <= bus.divisor;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (is_zero) begin
                dbz_q <= 1'b1;
                quo_q <= '1;
                rem_q <= bus.dividend[N-1:0];
            end else if (is_ovf) begin
                ovf_q <= 1'b1;
                quo_q <= '1;
                rem_q <= '0;
            end else begin
                r_q   <= {1'b0, bus.dividend[2*N-1:N]};
                q_q   <= bus.dividend[N-1:0];
                cnt_q <= '0;
            end
        end else if (state == RUN) begin
            r_q   <= r_step;
            q_q   <= q_step;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                quo_q <= q_step;
                rem_q <= r_step[N-1:0];
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign bus.state       = state;

`ifdef SEQ_DIV_CHECK_EN
    logic [2*N-1:0] dvd_chk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         dvd_chk_q <= '0;
        else if (accept) dvd_chk_q <= bus.dividend;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (state == DONE && !dbz_q && !ovf_q) begin
                assert ((2*N)'(quo_q) * (2*N)'(dvs_q) + (2*N)'(rem_q) == dvd_chk_q)
                    else $error("seq_divider_8bit: quotient*divisor+remainder != dividend");
                assert (rem_q < dvs_q)
                    else $error("seq_divider_8bit: remainder not below divisor");
            end
            if (bus.start && state == RUN)
                $warning("seq_divider_8bit: start asserted while busy, ignored");
        end
    end
`endif

endmodule

// File: doc/seq_divider_8bit.md
# seq_divider_8bit

Sequential restoring divider that inverts the array multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor and returns an N-bit quotient and an N-bit remainder. It produces one quotient bit per clock, using a start/done handshake. It sits beside the array multiplier in the arithmetic datapath and recovers operand A from product P and operand B.

## Interface
- `N`, default 8: operand width. The dividend is 2N bits; the quotient and remainder are N bits each.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: request. Sampled only while in IDLE or DONE.
- `dividend`, input, 2N: product-width numerator. Captured on an accepted `start`.
- `divisor`, input, N: denominator. Captured on an accepted `start`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when the results are valid.
- `quotient`, output, N: result. Held until the next accepted `start`.
- `remainder`, output, N: result. Held until the next accepted `start`.
- `div_by_zero`, output, 1: the captured divisor was 0. Valid with `done` and held.
- `overflow`, output, 1: the quotient does not fit in N bits. Valid with `done` and held.

## Operation
- **States:** IDLE, RUN, DONE, encoded as a 2-bit enum.
- **IDLE or DONE, `start`=1:**
  - Capture the operands and clear the error flags.
  - If divisor==0: set `div_by_zero`, load quotient={N{1}} and remainder=dividend[N-1:0], then go to DONE.
  - Else if dividend[2N-1:N] >= divisor: set `overflow`, load quotient={N{1}} and remainder={N{0}}, then go to DONE.
  - Else: load R = {1'b0, dividend[2N-1:N]} (N+1 bits) and Q = dividend[N-1:0], clear the iteration counter, then go to RUN.
- **RUN, each cycle:**
  - Shift {R,Q} left by 1.
  - If R >= {1'b0, divisor}, set R = R - divisor and Q[0] = 1.
  - After N iterations (counter == N-1), go to DONE.
  - `start` is ignored.
- **Leaving RUN:** quotient=Q and remainder=R[N-1:0]. Because R < divisor before every step, R never exceeds N+1 bits.
- **DONE:** `done`=1 for exactly this cycle. Then go to IDLE, or back to RUN or DONE if `start` is high in this cycle.
- **Result holding:** `quotient`, `remainder` and the flags hold their values across IDLE.
- **Dividend of 0 with a nonzero divisor:** takes the normal RUN path and gives quotient 0, remainder 0.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE. Asserting `rst` mid-RUN aborts the operation immediately; no `done` is issued.
- **Normal latency:** with `start` accepted at edge k, `busy` is high for cycles k+1..k+N and `done` is high in cycle k+N+1. That is 9 cycles at N=8.
- **Error latency:** `done` is high in cycle k+1 and `busy` never rises.
- **Throughput:** back-to-back issue is possible by asserting `start` during the `done` cycle. That gives one result per N+1 cycles.
- **Result validity:** `quotient` and `remainder` change only on the edge that enters DONE.

## Configuration
- **`SEQ_DIV_CHECK_EN` defined:** adds simulation-only immediate assertions.
  - On `done` with no error flag set: quotient*divisor + remainder == dividend, and remainder < divisor.
  - `start` asserted while `busy` triggers a `$warning`.
- **`SEQ_DIV_CHECK_EN` undefined:** no checks are compiled. Cycle behaviour and outputs are identical in both builds.

## Structure
- **Package `seq_div_pkg`:**
  - `SEQ_DIV_N_DEFAULT` = 8.
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} seq_div_state_t`.
- **Sub-module `seq_div_step`:** combinational, one restoring step. Inputs are R, Q and divisor; outputs are the next R and Q. The top level holds the FSM, the counter and the output registers.

## Test plan
- **Normal division:** dividend=50, divisor=10 → `done` 9 cycles after `start`, quotient=5, remainder=0, flags 0, `busy` high for 8 cycles.
- **Maximum values:** dividend=65025, divisor=255 → quotient=255, remainder=0. Also dividend=255, divisor=1 → quotient=255, remainder=0. Also dividend=227, divisor=15 → quotient=15, remainder=2.
- **Overflow:** dividend=512, divisor=2 → `done` 1 cycle after `start`, `overflow`=1, quotient=0xFF, remainder=0.
- **Divide by zero:** dividend=100, divisor=0 → `done` after 1 cycle, `div_by_zero`=1, quotient=0xFF, remainder=100.
- **Start while busy, then back-to-back:** start 200/7, pulse `start` with 50/10 at cycle 3 → the second request is ignored and the result is quotient=28, remainder=4. Then assert `start` with 50/10 during the `done` cycle → the next result is 5 r0, 9 cycles later.
- **Reset mid-operation:** assert `rst` at cycle 4 of RUN → all outputs are 0 and there is no `done` pulse. A new 100/3 request then gives quotient=33, remainder=1.
